// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0-lite definitions: register numbers, Status bit layout, exception codes.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 10;
  localparam int unsigned STATUS_IM_HI = 15;
  localparam int unsigned IRQ_MAX      = 6;

  // Only IE, EXL and IM are storage; every other Status bit reads as zero.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FC03;

  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_OV  = 5'd12
  } exc_code_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_INT,
    EV_OV,
    EV_SYS,
    EV_ERET
  } exc_event_e;

  function automatic logic [31:0] cause_word(input logic [IRQ_MAX-1:0] ip,
                                             input exc_code_e code);
    return {16'h0000, ip, 3'b000, code, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_irq_sync.sv
// Two-flop synchronizer for asynchronous level inputs, async active-low reset.
module cp0_exc_ctrl_irq_sync #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0-lite exception/interrupt controller: Status/Cause/EPC upkeep and
// fetch redirect to the handler vector or back to EPC.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int unsigned NUM_IRQ    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [31:0]        pc_in,
  input  logic               ov_in,
  input  logic               syscall_in,
  input  logic               eret_in,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mtc0_we,
  input  logic [4:0]         mtc0_addr,
  input  logic [31:0]        mtc0_wdata,
  input  logic [4:0]         mfc0_addr,
  output logic [31:0]        mfc0_rdata,
  output logic               exc_take,
  output logic [31:0]        exc_target,
  output logic [31:0]        epc_out,
  output logic               status_ie
);

  logic [NUM_IRQ-1:0] irq_sync;
  logic [IRQ_MAX-1:0] ip;
  logic [IRQ_MAX-1:0] im;
  logic               ie, exl, irq_pending;
  exc_event_e         ev;

  logic [31:0] status_d, status_q;
  logic [31:0] epc_d, epc_q;
  exc_code_e   exc_code_d, exc_code_q;
  logic        exc_take_d, exc_take_q;
  logic [31:0] exc_target_d, exc_target_q;

  cp0_exc_ctrl_irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (irq_in),
    .q_out (irq_sync)
  );

  always_comb begin
    ip = '0;
    ip[NUM_IRQ-1:0] = irq_sync;
  end

  assign ie          = status_q[STATUS_IE];
  assign exl         = status_q[STATUS_EXL];
  assign im          = status_q[STATUS_IM_HI:STATUS_IM_LO];
  assign irq_pending = (|(ip & im)) & ie & ~exl;

  // EXL blocks interrupts/exceptions, so eret can only win while EXL=1.
  always_comb begin
    ev = EV_NONE;
    if (instr_valid) begin
      if (irq_pending) begin
        ev = EV_INT;
      end else if (!exl) begin
        if (ov_in)           ev = EV_OV;
        else if (syscall_in) ev = EV_SYS;
      end else if (eret_in) begin
        ev = EV_ERET;
      end
    end
  end

  always_comb begin
    status_d     = status_q;
    epc_d        = epc_q;
    exc_code_d   = exc_code_q;
    exc_take_d   = 1'b0;
    exc_target_d = exc_target_q;
    case (ev)
      EV_INT, EV_OV, EV_SYS: begin
        epc_d                = pc_in;
        status_d[STATUS_EXL] = 1'b1;
        exc_take_d           = 1'b1;
        exc_target_d         = EXC_VECTOR;
        if (ev == EV_INT)     exc_code_d = EXC_INT;
        else if (ev == EV_OV) exc_code_d = EXC_OV;
        else                  exc_code_d = EXC_SYS;
      end
      EV_ERET: begin
        status_d[STATUS_EXL] = 1'b0;
        exc_take_d           = 1'b1;
        exc_target_d         = epc_q;
      end
      default: begin
        if (mtc0_we) begin
          if (mtc0_addr == CP0_STATUS) status_d = mtc0_wdata & STATUS_WMASK;
          else if (mtc0_addr == CP0_EPC) epc_d = mtc0_wdata;
        end
      end
    endcase
  end

  always_comb begin
    mfc0_rdata = '0;
    case (mfc0_addr)
      CP0_STATUS: mfc0_rdata = status_q;
      CP0_CAUSE:  mfc0_rdata = cause_word(ip, exc_code_q);
      CP0_EPC:    mfc0_rdata = epc_q;
      default:    mfc0_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q     <= '0;
      epc_q        <= '0;
      exc_code_q   <= EXC_INT;
      exc_take_q   <= 1'b0;
      exc_target_q <= '0;
    end else begin
      status_q     <= status_d;
      epc_q        <= epc_d;
      exc_code_q   <= exc_code_d;
      exc_take_q   <= exc_take_d;
      exc_target_q <= exc_target_d;
    end
  end

  assign exc_take   = exc_take_q;
  assign exc_target = exc_target_q;
  assign epc_out    = epc_q;
  assign status_ie  = ie;

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0-lite exception/interrupt controller for the multi-cycle MIPS core.
- Consumes the ALU overflow flag, decoded syscall/eret strobes, and external interrupt lines.
- Maintains Status/Cause/EPC and redirects the PC fetch logic to the handler vector or back to EPC.
- Sits beside the ALU and the PC unit; the register file reaches it through mfc0/mtc0.

Parameters:
- EXC_VECTOR, 32'h0000_0180, handler entry address.
- NUM_IRQ, 6, number of external interrupt lines (max 6; they map to IP/IM bits 15:10).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- instr_valid  in  1  an instruction commits this cycle; all strobes below are qualified by it
- pc_in  in  32  PC of the committing instruction
- ov_in  in  1  ALU signed-overflow flag (add/sub)
- syscall_in  in  1  syscall decoded
- eret_in  in  1  eret decoded
- irq_in  in  NUM_IRQ  asynchronous external interrupt requests, level, active-high
- mtc0_we  in  1  CP0 write strobe (not qualified by instr_valid)
- mtc0_addr  in  5  CP0 register number
- mtc0_wdata  in  32  write data
- mfc0_addr  in  5  read register number
- mfc0_rdata  out  32  combinational read data
- exc_take  out  1  one-cycle redirect pulse
- exc_target  out  32  redirect address, valid while exc_take=1
- epc_out  out  32  current EPC
- status_ie  out  1  Status.IE

Behaviour:
- Registers:
  - Status (12): bit0 IE, bit1 EXL, bits15:10 IM; all other bits read 0.
  - Cause (13): bits6:2 ExcCode; bits15:10 IP, read-only, the synchronized irq levels; all other bits read 0.
  - EPC (14): 32-bit.
  - Any other mfc0_addr reads 32'h0.
- Reset values: Status=0, Cause.ExcCode=0, EPC=0, sync flops=0, exc_take=0, exc_target=0.
- irq_in passes through a 2-flop synchronizer per line, so IP reflects irq_in 2 cycles later.
- pending = |(IP & IM) & IE & ~EXL.
- Detection cycle t requires instr_valid=1. Priority: interrupt > ov_in > syscall_in > eret_in.
  - Interrupt: ExcCode=0.
  - Overflow: ExcCode=12.
  - Syscall: ExcCode=8.
- On the posedge ending cycle t, for an exception:
  - EPC<=pc_in, EXL<=1, ExcCode updated.
  - exc_take<=1 and exc_target<=EXC_VECTOR in cycle t+1 (latency 1).
  - The committing instruction's result is the pipeline's responsibility to squash.
- eret with EXL=1: EXL<=0, exc_take<=1, exc_target<=EPC, ExcCode unchanged.
- eret with EXL=0: ignored, no pulse.
- While EXL=1: ov_in, syscall_in and interrupts are ignored (no nesting, no EPC or ExcCode update). Interrupts stay pending in IP.
- exc_take is high for exactly one cycle. Back-to-back events are allowed; a new event in cycle t+1 produces a pulse in t+2.
- mtc0:
  - Writes Status (IE, EXL, IM bits only) or EPC.
  - Writes to Cause and to unmapped numbers are dropped.
  - If an exception or eret updates state in the same cycle, the mtc0 write is discarded entirely.
- mfc0 returns the current register contents, before any same-cycle write.
- Reset asserted mid-handler clears EXL, IE and EPC immediately; no pulse is produced.
- An interrupt taken on the same cycle as eret cannot occur (EXL=1 blocks it). It fires on a later commit once EXL=0, if still pending.

Decomposition:
- Shared package or include file holds:
  - CP0 register numbers: 12, 13, 14.
  - Status bit positions: IE=0, EXL=1, IM=15:10.
  - ExcCode constants: INT=0, SYS=8, OV=12.
- Sub-module irq_sync: parameterized-width 2-flop synchronizer with async active-low reset.

Test Plan:
- Reset, then mfc0 12/13/14 -> all return 0; exc_take=0.
- instr_valid=1, ov_in=1, pc_in=32'h0040_0010 -> next cycle exc_take=1, exc_target=32'h0000_0180; EPC=32'h0040_0010, Cause[6:2]=12, EXL=1.
- mtc0 Status=32'h0000_0401 (IE=1, IM0=1); raise irq_in[0]. After 2 sync cycles, commit with pc_in=32'h0040_0020 -> exc_take=1, ExcCode=0, EPC=32'h0040_0020.
- In handler (EXL=1): syscall_in=1 -> no pulse, EPC unchanged. Then eret -> exc_take=1, exc_target=EPC, EXL=0.
- eret with EXL=0 -> no pulse. Same cycle ov_in=1 and syscall_in=1 -> ExcCode=12. Same cycle mtc0 EPC=32'hDEAD_BEEF and ov -> EPC=pc_in.
- Assert reset mid-handler -> Status=0, EPC=0, exc_take=0. A subsequent irq with IE=0 -> no pulse.
